// File: rtl/register_file_pkg.sv
// Shared definitions for the register file family.
// Provides the default word width / register count and the CeilLog2
// helper used to size register address ports.
package register_file_pkg;

  localparam int DEFAULT_WORD_LENGTH = 32;
  localparam int DEFAULT_NREGS       = 32;

  // Smallest n such that 2**n >= value (value >= 2 in practice).
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/register_bank_write_decoder.sv
// write_decoder: NREGS-way one-hot address decoder with enable.
// Ports:
//   enable  - when 0 the output is all zeros
//   address - register address; values >= NREGS decode to all zeros
//   one_hot - one bit per register, at most one bit set
module write_decoder
  import register_file_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS,
  parameter int NBITS = CeilLog2(DEFAULT_NREGS)
) (
  input  logic             enable,
  input  logic [NBITS-1:0] address,
  output logic [NREGS-1:0] one_hot
);

  // Compare the address against every register index; out-of-range
  // addresses match nothing, so they fall out naturally.
  always_comb begin
    one_hot = '0;
    for (int i = 0; i < NREGS; i++) begin
      one_hot[i] = enable && (address == NBITS'(i));
    end
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: multi-ported register file with a per-register busy
// (pending-write) scoreboard.
// Ports:
//   clk, reset                 - clock, synchronous active-low reset
//   Write_Enable/Register/Data - single write port
//   Read_Register_1/2          - read addresses
//   Read_Data_1/2              - combinational read data (with optional
//                                write-to-read forwarding)
//   Reserve_Enable/Register    - marks a register as pending a write
//   Busy_1/2                   - stored busy bit of each read address
module register_bank
  import register_file_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int NREGS       = DEFAULT_NREGS,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  localparam int NBITS      = CeilLog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Write_Enable,
  input  logic [NBITS-1:0]       Write_Register,
  input  logic [WORD_LENGTH-1:0] Write_Data,
  input  logic [NBITS-1:0]       Read_Register_1,
  input  logic [NBITS-1:0]       Read_Register_2,
  output logic [WORD_LENGTH-1:0] Read_Data_1,
  output logic [WORD_LENGTH-1:0] Read_Data_2,
  input  logic                   Reserve_Enable,
  input  logic [NBITS-1:0]       Reserve_Register,
  output logic                   Busy_1,
  output logic                   Busy_2
);

  // Registers that can actually hold state: register 0 is excluded when
  // it is hardwired to zero.
  localparam logic [NREGS-1:0] LEGAL_MASK = {{(NREGS-1){1'b1}}, (ZERO_REG == 0)};

  logic [NREGS-1:0]       write_hot_raw_s;
  logic [NREGS-1:0]       reserve_hot_raw_s;
  logic [NREGS-1:0]       write_hot_s;
  logic [NREGS-1:0]       reserve_hot_s;
  logic                   write_legal_s;
  logic [WORD_LENGTH-1:0] regs_r [NREGS];
  logic [NREGS-1:0]       busy_r;
  logic [WORD_LENGTH-1:0] read_data_1_s;
  logic [WORD_LENGTH-1:0] read_data_2_s;
  logic                   busy_1_s;
  logic                   busy_2_s;

  write_decoder #(
    .NREGS (NREGS),
    .NBITS (NBITS)
  ) u_write_dec (
    .enable  (Write_Enable),
    .address (Write_Register),
    .one_hot (write_hot_raw_s)
  );

  write_decoder #(
    .NREGS (NREGS),
    .NBITS (NBITS)
  ) u_reserve_dec (
    .enable  (Reserve_Enable),
    .address (Reserve_Register),
    .one_hot (reserve_hot_raw_s)
  );

  // Drop writes/reserves aimed at a hardwired-zero register 0.
  always_comb begin
    write_hot_s   = write_hot_raw_s & LEGAL_MASK;
    reserve_hot_s = reserve_hot_raw_s & LEGAL_MASK;
    write_legal_s = |write_hot_s;
  end

  // Register storage and busy scoreboard; reserve is applied after the
  // write clear so a same-cycle reserve keeps the register busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      busy_r <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (write_hot_s[i]) begin
          regs_r[i] <= Write_Data;
        end
      end
      busy_r <= (busy_r & ~write_hot_s) | reserve_hot_s;
    end
  end

  // Read muxes. Busy never forwards; data forwards the in-flight legal
  // write when BYPASS is enabled (also while reset is asserted).
  always_comb begin
    read_data_1_s = '0;
    read_data_2_s = '0;
    busy_1_s      = 1'b0;
    busy_2_s      = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (LEGAL_MASK[i] && (Read_Register_1 == NBITS'(i))) begin
        read_data_1_s = regs_r[i];
        busy_1_s      = busy_r[i];
      end else begin
        read_data_1_s = read_data_1_s;
        busy_1_s      = busy_1_s;
      end
      if (LEGAL_MASK[i] && (Read_Register_2 == NBITS'(i))) begin
        read_data_2_s = regs_r[i];
        busy_2_s      = busy_r[i];
      end else begin
        read_data_2_s = read_data_2_s;
        busy_2_s      = busy_2_s;
      end
    end
    if ((BYPASS != 0) && write_legal_s && (Write_Register == Read_Register_1)) begin
      read_data_1_s = Write_Data;
    end else begin
      read_data_1_s = read_data_1_s;
    end
    if ((BYPASS != 0) && write_legal_s && (Write_Register == Read_Register_2)) begin
      read_data_2_s = Write_Data;
    end else begin
      read_data_2_s = read_data_2_s;
    end
  end

  assign Read_Data_1 = read_data_1_s;
  assign Read_Data_2 = read_data_2_s;
  assign Busy_1      = busy_1_s;
  assign Busy_2      = busy_2_s;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank. Four instances share one set of inputs:
//   0: defaults, 1: BYPASS=0, 2: NREGS=24, 3: ZERO_REG=0.
// A behavioural model (plain arrays) predicts every instance's outputs.
module tb_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic        re;
  logic [4:0]  ra;

  logic [3:0][31:0] rd1;
  logic [3:0][31:0] rd2;
  logic [3:0]       b1;
  logic [3:0]       b2;

  register_bank dut0 (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(r1), .Read_Register_2(r2), .Read_Data_1(rd1[0]), .Read_Data_2(rd2[0]),
    .Reserve_Enable(re), .Reserve_Register(ra), .Busy_1(b1[0]), .Busy_2(b2[0]));

  register_bank #(.BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(r1), .Read_Register_2(r2), .Read_Data_1(rd1[1]), .Read_Data_2(rd2[1]),
    .Reserve_Enable(re), .Reserve_Register(ra), .Busy_1(b1[1]), .Busy_2(b2[1]));

  register_bank #(.NREGS(24)) dut2 (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(r1), .Read_Register_2(r2), .Read_Data_1(rd1[2]), .Read_Data_2(rd2[2]),
    .Reserve_Enable(re), .Reserve_Register(ra), .Busy_1(b1[2]), .Busy_2(b2[2]));

  register_bank #(.ZERO_REG(0)) dut3 (
    .clk(clk), .reset(reset), .Write_Enable(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(r1), .Read_Register_2(r2), .Read_Data_1(rd1[3]), .Read_Data_2(rd2[3]),
    .Reserve_Enable(re), .Reserve_Register(ra), .Busy_1(b1[3]), .Busy_2(b2[3]));

  int checks = 0;
  int errors = 0;

  // Model state: contents and busy flags of each instance.
  logic [31:0] m_mem  [4][32];
  bit          m_busy [4][32];

  typedef struct {
    bit          rst;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    bit          re;
    logic [4:0]  ra;
    logic [31:0] d1;
    logic [31:0] d2;
    bit          b1;
    bit          b2;
  } vec_t;

  vec_t tbl [$];

  function automatic int nr(int k);
    return (k == 2) ? 24 : 32;
  endfunction

  function automatic bit zr(int k);
    return (k == 3) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit bp(int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit legal(int k, logic [4:0] a);
    return (int'(a) < nr(k)) && !(zr(k) && (a == 5'd0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_read(input int k, input logic [4:0] a,
                            output logic [31:0] d, output bit b);
    if (bp(k) && we && legal(k, wa) && (wa == a)) d = wd;
    else if (legal(k, a)) d = m_mem[k][a];
    else d = 32'd0;
    b = legal(k, a) ? m_busy[k][a] : 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    bit          b;
    for (int k = 0; k < 4; k++) begin
      model_read(k, r1, d, b);
      chk($sformatf("%s inst%0d rd1", tag, k), rd1[k], d);
      chk($sformatf("%s inst%0d busy1", tag, k), {31'd0, b1[k]}, {31'd0, b});
      model_read(k, r2, d, b);
      chk($sformatf("%s inst%0d rd2", tag, k), rd2[k], d);
      chk($sformatf("%s inst%0d busy2", tag, k), {31'd0, b2[k]}, {31'd0, b});
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[k][i]  = 32'd0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (we && legal(k, wa)) begin
          m_mem[k][wa]  = wd;
          m_busy[k][wa] = 1'b0;
        end
        if (re && legal(k, ra)) m_busy[k][ra] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit rst_v, input bit we_v, input logic [4:0] wa_v,
                       input logic [31:0] wd_v, input logic [4:0] r1_v,
                       input logic [4:0] r2_v, input bit re_v, input logic [4:0] ra_v);
    reset = rst_v; we = we_v; wa = wa_v; wd = wd_v;
    r1 = r1_v; r2 = r2_v; re = re_v; ra = ra_v;
  endtask

  task automatic add(input bit rst_v, input bit we_v, input logic [4:0] wa_v,
                     input logic [31:0] wd_v, input logic [4:0] r1_v, input logic [4:0] r2_v,
                     input bit re_v, input logic [4:0] ra_v, input logic [31:0] d1_v,
                     input logic [31:0] d2_v, input bit b1_v, input bit b2_v);
    vec_t v;
    v.rst = rst_v; v.we = we_v; v.wa = wa_v; v.wd = wd_v; v.r1 = r1_v; v.r2 = r2_v;
    v.re = re_v; v.ra = ra_v; v.d1 = d1_v; v.d2 = d2_v; v.b1 = b1_v; v.b2 = b2_v;
    tbl.push_back(v);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'd0;
        m_busy[k][i] = 1'b0;
      end
    end

    // Expected outputs of the default instance, sampled before each edge.
    //   rst we wa     wd            r1     r2     re ra     d1            d2            b1 b2
    add(1, 1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  0, 5'd0,  32'hDEADBEEF, 32'h00000000, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd5,  5'd5,  0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    add(1, 1, 5'd0,  32'h12345678, 5'd0,  5'd0,  0, 5'd0,  32'h00000000, 32'h00000000, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  32'h00000000, 32'h00000000, 0, 0);
    add(1, 1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  0, 5'd0,  32'hDEADBEEF, 32'hA5A5A5A5, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd7,  5'd7,  0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd9,  5'd9,  1, 5'd9,  32'h00000000, 32'h00000000, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd9,  5'd9,  0, 5'd0,  32'h00000000, 32'h00000000, 1, 1);
    add(1, 1, 5'd9,  32'h11112222, 5'd9,  5'd5,  0, 5'd0,  32'h11112222, 32'hDEADBEEF, 1, 0);
    add(1, 0, 5'd0,  32'h0,        5'd9,  5'd9,  0, 5'd0,  32'h11112222, 32'h11112222, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd9,  5'd9,  1, 5'd9,  32'h11112222, 32'h11112222, 0, 0);
    add(1, 1, 5'd9,  32'h33334444, 5'd9,  5'd9,  1, 5'd9,  32'h33334444, 32'h33334444, 1, 1);
    add(1, 0, 5'd0,  32'h0,        5'd9,  5'd9,  0, 5'd0,  32'h33334444, 32'h33334444, 1, 1);
    add(1, 0, 5'd0,  32'h0,        5'd3,  5'd9,  1, 5'd3,  32'h00000000, 32'h33334444, 0, 1);
    add(0, 1, 5'd3,  32'hFFFFFFFF, 5'd3,  5'd9,  0, 5'd0,  32'hFFFFFFFF, 32'h33334444, 1, 1);
    add(1, 0, 5'd0,  32'h0,        5'd3,  5'd9,  0, 5'd0,  32'h00000000, 32'h00000000, 0, 0);
    add(1, 1, 5'd30, 32'hCAFEF00D, 5'd30, 5'd5,  1, 5'd30, 32'hCAFEF00D, 32'h00000000, 0, 0);
    add(1, 0, 5'd0,  32'h0,        5'd30, 5'd30, 0, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D, 1, 1);

    // Reset with idle inputs, then check the cleared state.
    drive(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 5'd0);
    tick();
    tick();
    drive(1, 0, 5'd0, 32'd0, 5'd1, 5'd31, 0, 5'd0);
    #2;
    check_all("reset_state");
    chk("reset_state rd1", rd1[0], 32'd0);
    chk("reset_state busy2", {31'd0, b2[0]}, 32'd0);
    tick();

    // Directed vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2,
            tbl[i].re, tbl[i].ra);
      #2;
      check_all($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_rd1", i), rd1[0], tbl[i].d1);
      chk($sformatf("vec%0d tbl_rd2", i), rd2[0], tbl[i].d2);
      chk($sformatf("vec%0d tbl_busy1", i), {31'd0, b1[0]}, {31'd0, tbl[i].b1});
      chk($sformatf("vec%0d tbl_busy2", i), {31'd0, b2[0]}, {31'd0, tbl[i].b2});
      tick();
    end

    // Out-of-range write/reserve on the 24-register instance leaves r0..r23 alone.
    for (int i = 1; i < 24; i++) begin
      drive(1, 1, 5'(i), 32'h01010101 * 32'(i), 5'(i), 5'd30, 0, 5'd0);
      #2;
      check_all("fill");
      tick();
    end
    drive(1, 1, 5'd30, 32'hFFFF0000, 5'd30, 5'd30, 1, 5'd30);
    #2;
    check_all("oob_write");
    tick();
    drive(1, 0, 5'd0, 32'd0, 5'd30, 5'd30, 0, 5'd0);
    #2;
    check_all("oob_read");
    chk("oob_read n24 rd1", rd1[2], 32'd0);
    chk("oob_read n24 busy1", {31'd0, b1[2]}, 32'd0);
    for (int i = 0; i < 24; i++) begin
      r1 = 5'(i);
      r2 = 5'(i);
      #1;
      check_all("keep");
      chk($sformatf("keep n24 r%0d", i), rd1[2], (i == 0) ? 32'd0 : 32'h01010101 * 32'(i));
    end
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
      #2;
      check_all($sformatf("rand%0d", n));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
